bsram_port_arbiter: RTL and testbench
=====================================

Name: bsram_port_arbiter

Overview:
- Parametrised N-port front end that shares one single-port BSRAM between several requestors, e.g. CPU data, CPU fetch and the LCD VRAM scanner.
- Successor to the fixed two-client RAM/VRAM wiring: generalised in data width, address width, port count, BSRAM read latency and arbitration mode.
- Sits between the requestors and one BSRAM primitive wrapper; all requestor traffic and returned read data pass through it.
- Issues at most one memory command per cycle and routes each read's data back to the port that issued it.

Parameters:
- NUM_PORTS, 3, number of requestor ports (2..8).
- ADDR_W, 13, BSRAM word address width.
- DATA_W, 8, data width.
- READ_LATENCY, 1, BSRAM read latency in cycles after command sample: 1 = bypass mode, 2 = output register (oce) mode.
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (port 0 highest).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_PORTS  per-port request, held until granted.
- we  in  NUM_PORTS  per-port write enable (1 = write, 0 = read).
- addr  in  NUM_PORTS*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  packed write data; same packing as addr.
- gnt  out  NUM_PORTS  one-hot grant, combinational.
- rvalid  out  NUM_PORTS  one-hot read-data-valid pulse.
- rdata  out  DATA_W  read data, shared by all ports; qualified by rvalid.
- mem_ce  out  1  BSRAM clock enable / command valid.
- mem_we  out  1  BSRAM write enable.
- mem_ad  out  ADDR_W  BSRAM address.
- mem_din  out  DATA_W  BSRAM write data.
- mem_oce  out  1  BSRAM output register enable; tied 1 when READ_LATENCY=2, 0 otherwise.
- mem_dout  in  DATA_W  BSRAM read data.

Behaviour:
- Reset (async assert, sync release):
  - mem_ce=0, mem_we=0, mem_ad=0, mem_din=0, rvalid=0, rdata=0.
  - Round-robin pointer = port 0.
  - Read-tag pipeline cleared; reads in flight when rst asserts are dropped and never produce rvalid.
- Grant:
  - gnt is combinational from req and the priority state. gnt is all-zero while rst is high or req==0.
  - At most one gnt bit is set per cycle.
  - A requestor sees gnt[i]=1 in cycle t and may change req/we/addr/wdata at the following edge. The request is consumed at that edge.
  - req[i]=1 with gnt[i]=0 means the port is stalled; its inputs must be held stable.
- Round-robin (ARB_MODE=0):
  - Search starts at the pointer and wraps modulo NUM_PORTS.
  - After granting port k, the pointer becomes (k+1) mod NUM_PORTS. With no grant, the pointer is unchanged.
  - Starvation bound: any requesting port is granted within NUM_PORTS cycles.
- Fixed priority (ARB_MODE=1): the lowest-index requesting port wins. The pointer is unused.
- Command issue: a grant in cycle t registers the command into the mem_* outputs, which are valid throughout cycle t+1.
  - mem_ce=1; mem_we=we[k]; mem_ad=addr[k]; mem_din=wdata[k].
  - With no grant, mem_ce=0 and mem_we=0 in t+1; mem_ad and mem_din hold their previous values.
- Read return:
  - A read granted in cycle t drives rvalid[k]=1 for exactly one cycle, t+1+READ_LATENCY.
  - In that cycle rdata equals mem_dout, registered when READ_LATENCY=1 and passed through the output register path when READ_LATENCY=2.
  - Writes never produce rvalid.
  - A tag shift register of depth READ_LATENCY carries {valid, port index}.
- Throughput:
  - Back-to-back reads from different or identical ports are accepted every cycle.
  - rvalid pulses come back in grant order, one per cycle, with no bubbles inserted.
- Read after write, same address, consecutive grants: the read returns the newly written value. The write is committed at its t+1 edge, before the read samples.
- rdata holds its last value when rvalid==0.

Test Plan:
- Reset: assert rst mid-burst with 2 reads in flight -> gnt, rvalid and mem_ce go 0 immediately; no rvalid after release; first grant after release goes to port 0.
- Single port: port 1 writes 0xA5 to 0x0123, then reads 0x0123 (READ_LATENCY=1) -> read granted in cycle t; mem_ce=1, mem_we=0, mem_ad=0x0123 in t+1; rvalid[1]=1 with rdata=0xA5 in t+2.
- Round-robin: all 3 ports hold req=1 with reads for 6 cycles from reset -> grant order 0,1,2,0,1,2; rvalid order identical, each exactly 2 cycles after its grant.
- Fixed priority (ARB_MODE=1): ports 0 and 2 request continuously for 4 cycles -> port 0 granted all 4 cycles, port 2 stalled; port 2 granted the cycle after port 0 drops req.
- Latency 2 (READ_LATENCY=2): read 0x1FFF holding 0x3C -> mem_oce=1; rvalid pulses 3 cycles after grant with rdata=0x3C.
- Mixed traffic: port 0 writes 0x11 to 0x0005 while port 1 reads 0x0005 on the next grant -> port 1 receives 0x11; no rvalid for the write; no cycle with mem_ce=1 and two gnt bits set.

Source files
------------

// File: rtl/bsram_port_arbiter.sv
// N-port arbiter in front of one single-port BSRAM: grants one request per
// cycle, registers it into the BSRAM command bus, and steers read data back.
// Ports: clk, rst (async, active-high); per-port req/we/addr/wdata in,
// gnt/rvalid out; shared rdata out; mem_ce/we/ad/din/oce out, mem_dout in.
module bsram_port_arbiter #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_ce,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_ad,
  output logic [DATA_W-1:0]           mem_din,
  output logic                        mem_oce,
  input  logic [DATA_W-1:0]           mem_dout
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W:0]   cand;
  logic             gnt_any;
  logic             sel_we;
  logic [ADDR_W-1:0] sel_ad;
  logic [DATA_W-1:0] sel_din;

  logic              mem_ce_q, mem_we_q;
  logic [ADDR_W-1:0] mem_ad_q;
  logic [DATA_W-1:0] mem_din_q;

  // Read tags: {valid, port}; the rvalid register is the final stage.
  logic [READ_LATENCY-1:0]            tag_v_q;
  logic [READ_LATENCY-1:0][IDX_W-1:0] tag_p_q;
  logic [NUM_PORTS-1:0]               rvalid_q;
  logic [DATA_W-1:0]                  rdata_q;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!rst) begin
      if (ARB_MODE == 1) begin
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
          if (req[i]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'(i);
          end
        end
      end else begin
        for (int off = 0; off < NUM_PORTS; off++) begin
          cand = {1'b0, ptr_q} + (IDX_W+1)'(off);
          if (cand >= (IDX_W+1)'(NUM_PORTS))
            cand = cand - (IDX_W+1)'(NUM_PORTS);
          if (!gnt_any && req[cand[IDX_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[IDX_W-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ARB_MODE == 0 && gnt_any)
      ptr_d = (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign gnt     = gnt_any ? (ONE << gnt_idx) : '0;
  assign sel_we  = we[gnt_idx];
  assign sel_ad  = addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_din = wdata[gnt_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      mem_ce_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_ad_q  <= '0;
      mem_din_q <= '0;
      tag_v_q   <= '0;
      tag_p_q   <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mem_ce_q <= gnt_any;
      mem_we_q <= gnt_any & sel_we;
      if (gnt_any) begin
        mem_ad_q  <= sel_ad;
        mem_din_q <= sel_din;
      end
      tag_v_q[0] <= gnt_any & ~sel_we;
      tag_p_q[0] <= gnt_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_p_q[i] <= tag_p_q[i-1];
      end
      rvalid_q <= tag_v_q[READ_LATENCY-1] ?
                  (ONE << tag_p_q[READ_LATENCY-1]) : '0;
      // Keep the last returned word so rdata holds between pulses.
      if (rvalid_q != '0)
        rdata_q <= mem_dout;
    end
  end

  assign rvalid  = rvalid_q;
  assign rdata   = (rvalid_q != '0) ? mem_dout : rdata_q;
  assign mem_ce  = mem_ce_q;
  assign mem_we  = mem_we_q;
  assign mem_ad  = mem_ad_q;
  assign mem_din = mem_din_q;
  assign mem_oce = (READ_LATENCY == 2);

endmodule

// File: tb/tb_bsram_port_arbiter.sv
// Bench for bsram_port_arbiter: round-robin/latency-1 and
// fixed-priority/latency-2 instances, each with a BSRAM model and scoreboard.
module tb_bsram_port_arbiter;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: round-robin, latency 1
  logic [2:0]  req_a = '0, we_a = '0;
  logic [38:0] addr_a = '0;
  logic [23:0] wdata_a = '0;
  logic [2:0]  gnt_a, rvalid_a;
  logic [7:0]  rdata_a, mem_din_a, mem_dout_a;
  logic        mem_ce_a, mem_we_a, mem_oce_a;
  logic [12:0] mem_ad_a;

  // instance B: fixed priority, latency 2
  logic [2:0]  req_b = '0, we_b = '0;
  logic [38:0] addr_b = '0;
  logic [23:0] wdata_b = '0;
  logic [2:0]  gnt_b, rvalid_b;
  logic [7:0]  rdata_b, mem_din_b, mem_dout_b, dout1_b;
  logic        mem_ce_b, mem_we_b, mem_oce_b;
  logic [12:0] mem_ad_b;

  logic [7:0] mem_a [8192];
  logic [7:0] ref_a [8192];
  logic [7:0] mem_b [8192];
  logic [7:0] ref_b [8192];
  exp_t q_a[$];
  exp_t q_b[$];

  bsram_port_arbiter #(.NUM_PORTS(3), .ADDR_W(13), .DATA_W(8),
    .READ_LATENCY(1), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .mem_ce(mem_ce_a), .mem_we(mem_we_a), .mem_ad(mem_ad_a),
    .mem_din(mem_din_a), .mem_oce(mem_oce_a), .mem_dout(mem_dout_a));

  bsram_port_arbiter #(.NUM_PORTS(3), .ADDR_W(13), .DATA_W(8),
    .READ_LATENCY(2), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
    .mem_ce(mem_ce_b), .mem_we(mem_we_b), .mem_ad(mem_ad_b),
    .mem_din(mem_din_b), .mem_oce(mem_oce_b), .mem_dout(mem_dout_b));

  // BSRAM models: bypass read for A, output-register read for B
  always @(posedge clk) begin
    if (mem_ce_a) begin
      if (mem_we_a) mem_a[mem_ad_a] <= mem_din_a;
      else          mem_dout_a <= mem_a[mem_ad_a];
    end
    if (mem_ce_b) begin
      if (mem_we_b) mem_b[mem_ad_b] <= mem_din_b;
      else          dout1_b <= mem_b[mem_ad_b];
    end
    if (mem_oce_b) mem_dout_b <= dout1_b;
  end

  // scoreboards: push at grant, pop on rvalid
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (gnt_a[k]) begin
          if (we_a[k]) ref_a[addr_a[k*13 +: 13]] = wdata_a[k*8 +: 8];
          else q_a.push_back('{k, ref_a[addr_a[k*13 +: 13]], cyc + 2});
        end
        if (gnt_b[k]) begin
          if (we_b[k]) ref_b[addr_b[k*13 +: 13]] = wdata_b[k*8 +: 8];
          else q_b.push_back('{k, ref_b[addr_b[k*13 +: 13]], cyc + 3});
        end
      end
      if (rvalid_a != 3'b000) begin
        total++;
        if (q_a.size() == 0) begin
          bad++;
          $display("FAIL sb_a_unexpected rvalid=%b want=000 cyc=%0d",
                   rvalid_a, cyc);
        end else begin
          e = q_a.pop_front();
          if (rvalid_a !== (3'b001 << e.port) || rdata_a !== e.data ||
              cyc != e.due) begin
            bad++;
            $display("FAIL sb_a rvalid=%b rdata=%h cyc=%0d want %b %h %0d",
                     rvalid_a, rdata_a, cyc, 3'b001 << e.port, e.data, e.due);
          end
        end
      end
      if (rvalid_b != 3'b000) begin
        total++;
        if (q_b.size() == 0) begin
          bad++;
          $display("FAIL sb_b_unexpected rvalid=%b want=000 cyc=%0d",
                   rvalid_b, cyc);
        end else begin
          e = q_b.pop_front();
          if (rvalid_b !== (3'b001 << e.port) || rdata_b !== e.data ||
              cyc != e.due) begin
            bad++;
            $display("FAIL sb_b rvalid=%b rdata=%h cyc=%0d want %b %h %0d",
                     rvalid_b, rdata_b, cyc, 3'b001 << e.port, e.data, e.due);
          end
        end
      end
    end
  end

  task automatic drv_a(input int p, input logic r, input logic w,
                       input logic [12:0] ad, input logic [7:0] d);
    req_a[p] = r;
    we_a[p] = w;
    addr_a[p*13 +: 13] = ad;
    wdata_a[p*8 +: 8] = d;
  endtask

  task automatic drv_b(input int p, input logic r, input logic w,
                       input logic [12:0] ad, input logic [7:0] d);
    req_b[p] = r;
    we_b[p] = w;
    addr_b[p*13 +: 13] = ad;
    wdata_b[p*8 +: 8] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int p = 0; p < 3; p++) drv_a(p, 1'b1, 1'b0, 13'(p), 8'h00);
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b000) begin
      bad++; $display("FAIL rst_gnt got=%b want=000", gnt_a);
    end
    total++;
    if (rvalid_a !== 3'b000 || rdata_a !== 8'h00) begin
      bad++; $display("FAIL rst_rd got=%b/%h want=000/00", rvalid_a, rdata_a);
    end
    total++;
    if (mem_ce_a !== 1'b0 || mem_we_a !== 1'b0 || mem_ad_a !== 13'h0 ||
        mem_din_a !== 8'h00) begin
      bad++;
      $display("FAIL rst_mem got=%b%b %h %h want=00 0000 00",
               mem_ce_a, mem_we_a, mem_ad_a, mem_din_a);
    end
    step();
    rst = 1'b0;
    req_a = 3'b000;
  endtask

  task automatic test_single();
    drv_a(1, 1'b1, 1'b1, 13'h0123, 8'hA5);
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b010) begin
      bad++; $display("FAIL single_wgnt got=%b want=010", gnt_a);
    end
    step();
    drv_a(1, 1'b1, 1'b0, 13'h0123, 8'h00);
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b010) begin
      bad++; $display("FAIL single_rgnt got=%b want=010", gnt_a);
    end
    step();
    req_a = 3'b000;
    @(negedge clk);
    total++;
    if (mem_ce_a !== 1'b1 || mem_we_a !== 1'b0 || mem_ad_a !== 13'h0123) begin
      bad++;
      $display("FAIL single_cmd got=%b%b %h want=10 0123",
               mem_ce_a, mem_we_a, mem_ad_a);
    end
    @(negedge clk);
    total++;
    if (rvalid_a !== 3'b010 || rdata_a !== 8'hA5) begin
      bad++;
      $display("FAIL single_rd got=%b/%h want=010/a5", rvalid_a, rdata_a);
    end
    step();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    q_a.delete();
    q_b.delete();
    step();
    rst = 1'b0;
    for (int p = 0; p < 3; p++) drv_a(p, 1'b1, 1'b0, 13'h0010 + 13'(p), 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (gnt_a !== (3'b001 << (i % 3))) begin
        bad++;
        $display("FAIL rr_gnt%0d got=%b want=%b", i, gnt_a, 3'b001 << (i % 3));
      end
      step();
    end
    req_a = 3'b000;
    repeat (3) step();
  endtask

  task automatic test_reset_midburst();
    for (int p = 0; p < 3; p++) drv_a(p, 1'b1, 1'b0, 13'h0020 + 13'(p), 8'h00);
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    rst = 1'b1;
    #1;
    total++;
    if (gnt_a !== 3'b000 || rvalid_a !== 3'b000 || mem_ce_a !== 1'b0) begin
      bad++;
      $display("FAIL midrst got=%b %b %b want=000 000 0",
               gnt_a, rvalid_a, mem_ce_a);
    end
    q_a.delete();
    q_b.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b001) begin
      bad++; $display("FAIL midrst_first got=%b want=001", gnt_a);
    end
    step();
    req_a = 3'b000;
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drv_a(2, 1'b1, 1'b0, 13'h0200 + 13'(i), 8'h00);
      @(negedge clk);
      total++;
      if (gnt_a !== 3'b100) begin
        bad++; $display("FAIL b2b_gnt%0d got=%b want=100", i, gnt_a);
      end
      step();
    end
    req_a = 3'b000;
    repeat (4) step();
  endtask

  task automatic test_mixed();
    drv_a(0, 1'b1, 1'b1, 13'h0005, 8'h11);
    drv_a(1, 1'b1, 1'b0, 13'h0005, 8'h00);
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b001) begin
      bad++; $display("FAIL mix_wgnt got=%b want=001", gnt_a);
    end
    step();
    req_a[0] = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b010) begin
      bad++; $display("FAIL mix_rgnt got=%b want=010", gnt_a);
    end
    step();
    req_a = 3'b000;
    @(negedge clk);
    total++;
    if (rvalid_a !== 3'b000) begin
      bad++; $display("FAIL mix_wr_norv got=%b want=000", rvalid_a);
    end
    @(negedge clk);
    total++;
    if (rvalid_a !== 3'b010 || rdata_a !== 8'h11) begin
      bad++; $display("FAIL mix_rd got=%b/%h want=010/11", rvalid_a, rdata_a);
    end
    step();
    repeat (2) step();
  endtask

  task automatic test_fixed_prio();
    drv_b(0, 1'b1, 1'b0, 13'h0040, 8'h00);
    drv_b(2, 1'b1, 1'b0, 13'h0042, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (gnt_b !== 3'b001) begin
        bad++; $display("FAIL fp_gnt%0d got=%b want=001", i, gnt_b);
      end
      step();
    end
    req_b[0] = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_b !== 3'b100) begin
      bad++; $display("FAIL fp_p2 got=%b want=100", gnt_b);
    end
    step();
    req_b = 3'b000;
    repeat (5) step();
  endtask

  task automatic test_latency2();
    total++;
    if (mem_oce_b !== 1'b1 || mem_oce_a !== 1'b0) begin
      bad++; $display("FAIL oce got=%b%b want=10", mem_oce_b, mem_oce_a);
    end
    drv_b(1, 1'b1, 1'b1, 13'h1FFF, 8'h3C);
    @(negedge clk);
    step();
    drv_b(1, 1'b1, 1'b0, 13'h1FFF, 8'h00);
    @(negedge clk);
    total++;
    if (gnt_b !== 3'b010) begin
      bad++; $display("FAIL l2_gnt got=%b want=010", gnt_b);
    end
    step();
    req_b = 3'b000;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if (rvalid_b !== ((i == 3) ? 3'b010 : 3'b000) ||
          (i == 3 && rdata_b !== 8'h3C)) begin
        bad++;
        $display("FAIL l2_rd t+%0d got=%b/%h want=%b/3c", i, rvalid_b,
                 rdata_b, (i == 3) ? 3'b010 : 3'b000);
      end
    end
    repeat (2) step();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem_a[i] = 8'(i) ^ 8'h5A;
      ref_a[i] = 8'(i) ^ 8'h5A;
      mem_b[i] = 8'(i) ^ 8'hC3;
      ref_b[i] = 8'(i) ^ 8'hC3;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_reset_midburst();
    test_back_to_back();
    test_mixed();
    test_fixed_prio();
    test_latency2();
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d/%0d want=0/0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
